// File: rtl/buzzer_player.sv
// -----------------------------------------------------------------------------
// buzzer_player
//
// Note-sequenced square-wave buzzer driver. A melody source hands over one note
// at a time (half-period count plus duration in ms) on a valid/ready handshake;
// the block plays it for exactly the requested time and pulses `done`. A
// half-period of 0 is a rest. `stop` aborts the current note or gap.
//
// Optional feature macro: BUZZER_GAP_EN
//   defined   - each completed note is followed by GAP_MS ms of silence
//               (GAP state) so repeated pitches are articulated.
//   undefined - no GAP state; notes play legato.
//
// Parameters:
//   CLK_HZ  clk frequency in Hz; CLK_HZ/1000 cycles make one ms tick (>= 1)
//   DIV_W   width of the half-period count
//   DUR_W   width of the duration in ms
//   GAP_MS  silent gap length in ms (>= 1, used only with BUZZER_GAP_EN)
//
// Ports:
//   clk         clock
//   resetn      synchronous active-low reset
//   note_valid  note request
//   note_ready  can accept a note (high only in IDLE, decoded from state)
//   note_half   half-period minus 1 in cycles; 0 = rest
//   note_dur    note length in ms; 0 completes immediately
//   stop        synchronous abort of PLAY/GAP, ignored in IDLE
//   busy        registered, high in any state other than IDLE
//   done        registered one-cycle pulse on normal note completion
//   buzzer      registered square-wave output
// -----------------------------------------------------------------------------
module buzzer_player #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned DUR_W  = 12,
    parameter int unsigned GAP_MS = 20
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [DIV_W-1:0] note_half,
    input  logic [DUR_W-1:0] note_dur,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic             buzzer
);

    localparam int unsigned TICK_DIV = CLK_HZ / 1000;
    localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

`ifdef BUZZER_GAP_EN
    localparam int unsigned GAP_W = $clog2(GAP_MS + 1);
    // ms_cnt is shared by PLAY and GAP, so it must hold either limit.
    localparam int unsigned CNT_W = (GAP_W > DUR_W) ? GAP_W : DUR_W;
`else
    localparam int unsigned CNT_W = DUR_W;
`endif

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    // Elaboration-time sanity checks on the configuration.
    if (TICK_DIV < 1) begin : g_bad_clk_hz
        $error("buzzer_player: CLK_HZ must be at least 1000");
    end
    if (GAP_MS < 1) begin : g_bad_gap_ms
        $error("buzzer_player: GAP_MS must be at least 1");
    end

`ifdef BUZZER_GAP_EN
    typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;
    // State entered once a note has completed normally.
    localparam state_e StAfter = StGap;
`else
    typedef enum logic [0:0] {StIdle, StPlay} state_e;
    localparam state_e StAfter = StIdle;
`endif

    state_e state_q, state_d;

    logic [DIV_W-1:0] half_q, half_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [DIV_W-1:0] tone_cnt_q, tone_cnt_d;
    logic [PRE_W-1:0] ms_pre_q, ms_pre_d;
    logic [CNT_W-1:0] ms_cnt_q, ms_cnt_d;
    logic             buzzer_q, buzzer_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [DUR_W-1:0] dur_last;
    logic             ms_wrap;
    logic             play_end;
`ifdef BUZZER_GAP_EN
    logic             gap_end;
`endif

    // dur_q is never 0 while in PLAY, so dur_last never underflows in use.
    assign dur_last = dur_q - DUR_W'(1);
    assign ms_wrap  = (ms_pre_q == PRE_LAST);
    assign play_end = (state_q == StPlay) && ms_wrap && (ms_cnt_q == CNT_W'(dur_last));
`ifdef BUZZER_GAP_EN
    assign gap_end  = (state_q == StGap) && ms_wrap && (ms_cnt_q == CNT_W'(GAP_MS - 1));
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                // stop is ignored here; a simultaneous note is still accepted.
                if (note_valid) begin
                    state_d = (note_dur == '0) ? StAfter : StPlay;
                end
            end
            StPlay: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (play_end) begin
                    state_d = StAfter;
                end
            end
`ifdef BUZZER_GAP_EN
            StGap: begin
                if (stop || gap_end) begin
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath next-value logic
    // -------------------------------------------------------------------------
    always_comb begin
        half_d     = half_q;
        dur_d      = dur_q;
        tone_cnt_d = tone_cnt_q;
        ms_pre_d   = ms_pre_q;
        ms_cnt_d   = ms_cnt_q;
        buzzer_d   = buzzer_q;
        done_d     = 1'b0;
        busy_d     = (state_d != StIdle);

        case (state_q)
            StIdle: begin
                buzzer_d = 1'b0;
                if (note_valid) begin
                    half_d     = note_half;
                    dur_d      = note_dur;
                    tone_cnt_d = '0;
                    ms_pre_d   = '0;
                    ms_cnt_d   = '0;
                    // A zero-length note completes on the accept edge itself.
                    done_d     = (note_dur == '0);
                end
            end

            StPlay: begin
                if (stop || play_end) begin
                    // Counters restart so GAP (if present) times from zero.
                    buzzer_d   = 1'b0;
                    done_d     = !stop;
                    tone_cnt_d = '0;
                    ms_pre_d   = '0;
                    ms_cnt_d   = '0;
                end else begin
                    // Tone generator: each level lasts half+1 cycles.
                    if (half_q == '0) begin
                        buzzer_d = 1'b0;
                    end else if (tone_cnt_q >= half_q) begin
                        tone_cnt_d = '0;
                        buzzer_d   = !buzzer_q;
                    end else begin
                        tone_cnt_d = tone_cnt_q + DIV_W'(1);
                    end

                    // Millisecond prescaler and counter.
                    if (ms_wrap) begin
                        ms_pre_d = '0;
                        ms_cnt_d = ms_cnt_q + CNT_W'(1);
                    end else begin
                        ms_pre_d = ms_pre_q + PRE_W'(1);
                    end
                end
            end

`ifdef BUZZER_GAP_EN
            StGap: begin
                buzzer_d = 1'b0;
                if (stop || gap_end) begin
                    ms_pre_d = '0;
                    ms_cnt_d = '0;
                end else if (ms_wrap) begin
                    ms_pre_d = '0;
                    ms_cnt_d = ms_cnt_q + CNT_W'(1);
                end else begin
                    ms_pre_d = ms_pre_q + PRE_W'(1);
                end
            end
`endif

            default: begin
                buzzer_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            half_q     <= '0;
            dur_q      <= '0;
            tone_cnt_q <= '0;
            ms_pre_q   <= '0;
            ms_cnt_q   <= '0;
            buzzer_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            half_q     <= half_d;
            dur_q      <= dur_d;
            tone_cnt_q <= tone_cnt_d;
            ms_pre_q   <= ms_pre_d;
            ms_cnt_q   <= ms_cnt_d;
            buzzer_q   <= buzzer_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign note_ready = (state_q == StIdle);
    assign busy       = busy_q;
    assign done       = done_q;
    assign buzzer     = buzzer_q;

endmodule

// File: tb/tb_buzzer_player.sv
module tb_buzzer_player;

    localparam int unsigned CLK_HZ = 10_000;
    localparam int          TD     = 10;
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned DUR_W  = 12;
    localparam int unsigned GAP_MS = 2;
`ifdef BUZZER_GAP_EN
    localparam int GAP_CYC = GAP_MS * TD;
`else
    localparam int GAP_CYC = 0;
`endif

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             note_valid = 1'b0;
    logic             stop = 1'b0;
    logic [DIV_W-1:0] note_half = '0;
    logic [DUR_W-1:0] note_dur = '0;
    logic             note_ready, busy, done, buzzer;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    buzzer_player #(
        .CLK_HZ (CLK_HZ),
        .DIV_W  (DIV_W),
        .DUR_W  (DUR_W),
        .GAP_MS (GAP_MS)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_half  (note_half),
        .note_dur   (note_dur),
        .stop       (stop),
        .busy       (busy),
        .done       (done),
        .buzzer     (buzzer)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One note per record; k counts edges after the accept edge (k=0 right after it).
    typedef struct {
        int half;
        int dur;
        int stop_at;     // edge at which stop is sampled (0 = never)
        int exp_end;     // first k with note_ready=1
        int exp_dones;
        int exp_done_at;
        int exp_rises;
        int exp_first;   // k of first buzzer rise, -1 if none
        int exp_highs;
        int exp_busy;
    } note_vec_t;

    task automatic run_note(input note_vec_t v, input int idx);
        int   k_end   = -1;
        int   dones   = 0;
        int   done_at = -1;
        int   rises   = 0;
        int   first   = -1;
        int   highs   = 0;
        int   busy_n  = 0;
        logic prev    = 1'b0;
        note_valid = 1'b1;
        note_half  = DIV_W'(v.half);
        note_dur   = DUR_W'(v.dur);
        tick();
        note_valid = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (buzzer && !prev) begin
                rises++;
                if (first < 0) first = k;
            end
            prev = buzzer;
            if (buzzer) highs++;
            if (busy) busy_n++;
            if (done) begin
                dones++;
                if (done_at < 0) done_at = k;
            end
            if (note_ready && k_end < 0) k_end = k;
            stop = (v.stop_at > 0) && (k == v.stop_at - 1);
            tick();
        end
        stop = 1'b0;
        check($sformatf("vec%0d end", idx), k_end, v.exp_end);
        check($sformatf("vec%0d done_count", idx), dones, v.exp_dones);
        check($sformatf("vec%0d done_at", idx), done_at, v.exp_done_at);
        check($sformatf("vec%0d rises", idx), rises, v.exp_rises);
        check($sformatf("vec%0d first_rise", idx), first, v.exp_first);
        check($sformatf("vec%0d high_cycles", idx), highs, v.exp_highs);
        check($sformatf("vec%0d busy_cycles", idx), busy_n, v.exp_busy);
    endtask

    note_vec_t vecs[8];

    initial begin
        // Derived by hand from: level changes whenever k is a multiple of half+1,
        // note ends (buzzer forced low) at k = dur*10.
        vecs[0] = '{4, 3, 0, 30, 1, 30, 3, 5, 15, 30};
        vecs[1] = '{0, 2, 0, 20, 1, 20, 0, -1, 0, 20};
        vecs[2] = '{3, 5, 13, 13, 0, -1, 2, 4, 5, 13};
        vecs[3] = '{0, 0, 0, 0, 1, 0, 0, -1, 0, 0};
        vecs[4] = '{5, 0, 0, 0, 1, 0, 0, -1, 0, 0};
        vecs[5] = '{1, 1, 0, 10, 1, 10, 2, 2, 4, 10};
        vecs[6] = '{2, 1, 0, 10, 1, 10, 2, 3, 4, 10};
        vecs[7] = '{12, 4, 0, 40, 1, 40, 2, 13, 14, 40};
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].exp_dones == 1) begin
                vecs[i].exp_end  += GAP_CYC;
                vecs[i].exp_busy += GAP_CYC;
            end
        end

        // Reset state
        resetn = 1'b0;
        repeat (3) tick();
        check("reset note_ready", int'(note_ready), 1);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset buzzer", int'(buzzer), 0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_note(vecs[i], i);

        // stop together with note_valid in IDLE: the note is accepted
        begin
            int dones = 0;
            note_valid = 1'b1;
            stop       = 1'b1;
            note_half  = 3;
            note_dur   = 1;
            tick();
            note_valid = 1'b0;
            stop       = 1'b0;
            check("idle_stop busy", int'(busy), 1);
            check("idle_stop note_ready", int'(note_ready), 0);
            for (int k = 0; k < 12 + GAP_CYC; k++) begin
                if (done) dones++;
                tick();
            end
            check("idle_stop done_count", dones, 1);
            check("idle_stop back_idle", int'(note_ready), 1);
        end

        // Reset in the middle of PLAY
        begin
            int dones = 0;
            int busy_n = 0;
            note_valid = 1'b1;
            note_half  = 1;
            note_dur   = 3;
            tick();
            note_valid = 1'b0;
            repeat (6) tick();
            check("midreset buzzer_before", int'(buzzer), 1);
            resetn = 1'b0;
            tick();
            check("midreset buzzer", int'(buzzer), 0);
            check("midreset busy", int'(busy), 0);
            check("midreset note_ready", int'(note_ready), 1);
            check("midreset done", int'(done), 0);
            resetn = 1'b1;
            for (int k = 0; k < 40; k++) begin
                if (done) dones++;
                if (busy) busy_n++;
                tick();
            end
            check("midreset later_dones", dones, 0);
            check("midreset later_busy", busy_n, 0);
        end

`ifdef BUZZER_GAP_EN
        // Gap: done at 10, note_ready low until 30, buzzer silent in the gap
        begin
            int done_at = -1;
            int ready_at = -1;
            int gap_highs = 0;
            note_valid = 1'b1;
            note_half  = 4;
            note_dur   = 1;
            tick();
            note_valid = 1'b0;
            for (int k = 0; k < 45; k++) begin
                if (done && done_at < 0) done_at = k;
                if (note_ready && ready_at < 0) ready_at = k;
                if (k >= 10 && k <= 30 && buzzer) gap_highs++;
                tick();
            end
            check("gap done_at", done_at, 10);
            check("gap ready_at", ready_at, 30);
            check("gap buzzer_highs", gap_highs, 0);
        end
`else
        // Back-to-back: valid held, second note accepted in the done cycle
        begin
            int d1 = -1;
            int d2 = -1;
            int acc2 = -1;
            int hi2 = 0;
            note_valid = 1'b1;
            note_half  = 2;
            note_dur   = 1;
            tick();
            for (int k = 0; k < 40; k++) begin
                if (done) begin
                    if (d1 < 0) d1 = k;
                    else if (d2 < 0) d2 = k;
                end
                if (d1 >= 0 && k > d1 && acc2 < 0 && busy) begin
                    acc2 = k;
                    note_valid = 1'b0;
                end
                if (acc2 >= 0 && buzzer) hi2++;
                if (done && d1 == k) begin
                    note_half = 9;
                    note_dur  = 1;
                end
                tick();
            end
            note_valid = 1'b0;
            check("b2b first_done", d1, 10);
            check("b2b second_accept", acc2, 11);
            check("b2b second_done", d2, 21);
            check("b2b second_highs", hi2, 0);
        end

        // Randomized run against a note-level behavioural model
        begin
            bit m_active = 1'b0;
            bit m_done = 1'b0;
            int m_t = 0;
            int m_h = 0;
            int m_d = 0;
            int exp_buzz;
            resetn = 1'b0;
            tick();
            resetn = 1'b1;
            for (int c = 0; c < 3000; c++) begin
                resetn     = ($urandom_range(0, 199) != 0);
                note_valid = ($urandom_range(0, 2) == 0);
                note_half  = DIV_W'($urandom_range(0, 6));
                note_dur   = DUR_W'($urandom_range(0, 3));
                stop       = ($urandom_range(0, 39) == 0);
                @(posedge clk);
                if (!resetn) begin
                    m_active = 1'b0;
                    m_done   = 1'b0;
                end else if (!m_active) begin
                    m_done = 1'b0;
                    if (note_valid) begin
                        if (note_dur == 0) begin
                            m_done = 1'b1;
                        end else begin
                            m_active = 1'b1;
                            m_t = 0;
                            m_h = int'(note_half);
                            m_d = int'(note_dur);
                        end
                    end
                end else begin
                    m_t++;
                    m_done = 1'b0;
                    if (stop) begin
                        m_active = 1'b0;
                    end else if (m_t == m_d * TD) begin
                        m_active = 1'b0;
                        m_done = 1'b1;
                    end
                end
                exp_buzz = (m_active && m_h != 0) ? ((m_t / (m_h + 1)) % 2) : 0;
                #1;
                check($sformatf("rand%0d buzzer", c), int'(buzzer), exp_buzz);
                check($sformatf("rand%0d done", c), int'(done), int'(m_done));
                check($sformatf("rand%0d busy", c), int'(busy), int'(m_active));
                check($sformatf("rand%0d note_ready", c), int'(note_ready), int'(!m_active));
            end
            resetn = 1'b1;
            note_valid = 1'b0;
            stop = 1'b0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
